// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and the
// clogb2 width helper used to size the prescaler counter.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    // Bits needed to hold 'value'; never less than 1.
    function automatic int clogb2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle of the interval timer. master drives commands,
// slave (the timer) drives status.
interface interval_timer_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             hold;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] remaining;
    logic             tick;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output start, hold, load_val,
        input  remaining, tick, done, busy, state
    );

    modport slave (
        input  start, hold, load_val,
        output remaining, tick, done, busy, state
    );
endinterface

// File: rtl/prescaler_mod_m.sv
// Modulo-M counter; rollover is high while the count sits at M-1.
module prescaler_mod_m
    import timer_pkg::*;
#(
    parameter int M = 20
) (
    input  logic clk,
    input  logic aclr,
    input  logic clr,
    input  logic en,
    output logic rollover
);
    localparam int             W    = clogb2(M - 1);
    localparam logic [W-1:0]   LAST = W'(M - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (aclr || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign rollover = (cnt == LAST);
endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer: counts load_val prescaled ticks, with pause and restart.
// Define TIMER_AUTORELOAD_EN to reload from the start value and keep running.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int PRESCALE = 20,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 aclr,
    interval_timer_ctrl_if.slave bus
);
    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             rollover, tick, pre_clr, pre_en;

`ifdef TIMER_AUTORELOAD_EN
    logic [CNT_W-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (aclr)           reload_q <= '0;
        else if (bus.start) reload_q <= bus.load_val;
    end
`endif

    // Prescaler only moves in RUN when neither start nor hold overrides it.
    assign pre_en  = (state_q == ST_RUN) && !bus.start && !bus.hold;
    assign pre_clr = bus.start || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign tick    = rollover && pre_en && !aclr;

    prescaler_mod_m #(.M(PRESCALE)) u_prescaler (
        .clk      (clk),
        .aclr     (aclr),
        .clr      (pre_clr),
        .en       (pre_en),
        .rollover (rollover)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (bus.start) begin
            rem_d = bus.load_val;
            if (bus.load_val == '0) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.hold) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (rem_q <= CNT_W'(1)) begin
                            done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                            rem_d  = reload_q;
`else
                            rem_d   = '0;
                            state_d = ST_DONE;
`endif
                        end else begin
                            rem_d = rem_q - CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.hold) state_d = ST_RUN;
                end
                ST_DONE: rem_d = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign bus.remaining = rem_q;
    assign bus.tick      = tick;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.state     = state_q;
endmodule
